// File: rtl/pov_fb_arbiter.sv
// rtl/pov_fb_arbiter.sv - single-port framebuffer arbiter: LED readout vs queued CPU pixel writes
//
// Purpose:
//   Shares one single-port framebuffer RAM between the LED readout path and CPU
//   pixel writes. Readout always wins and has a fixed 3-cycle latency. CPU
//   writes wait in a small FIFO and drain into cycles with no readout request.
//
// Configuration macro: POV_FB_DOUBLE_BUFFER_EN
//   Defined     : two banks. CPU writes target the back bank. A swap request
//                 commits only on a theta wrap, after the write FIFO has drained.
//   Not defined : single bank (fb_addr MSB is 0). swap_done echoes swap_req one
//                 cycle later, so software that polls for it still works.
//
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_rd_req, i_rd_addr    readout request and pixel address
//   o_rd_data, o_rd_valid  readout pixel, valid 3 cycles after the request
//   i_cpu_wr_valid/addr/data, o_cpu_wr_ready
//                          CPU write handshake; a write transfers when valid && ready
//   i_swap_req, i_theta    bank swap request and current angular index
//   o_swap_pending         swap requested but not yet committed
//   o_swap_done            1-cycle pulse when the swap commits
//   o_fifo_level           number of queued CPU writes
//   o_fb_en, o_fb_we, o_fb_addr, o_fb_wdata
//                          registered RAM command; the address is {bank, addr}
//   i_fb_rdata             RAM read data, valid 1 cycle after a read command
module pov_fb_arbiter #(
    parameter int ADDR_BITS  = 14,
    parameter int DATA_BITS  = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int THETA_BITS = 6
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_rd_req,
    input  logic [ADDR_BITS-1:0]            i_rd_addr,
    output logic [DATA_BITS-1:0]            o_rd_data,
    output logic                            o_rd_valid,
    input  logic                            i_cpu_wr_valid,
    output logic                            o_cpu_wr_ready,
    input  logic [ADDR_BITS-1:0]            i_cpu_wr_addr,
    input  logic [DATA_BITS-1:0]            i_cpu_wr_data,
    input  logic                            i_swap_req,
    input  logic [THETA_BITS-1:0]           i_theta,
    output logic                            o_swap_pending,
    output logic                            o_swap_done,
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level,
    output logic                            o_fb_en,
    output logic                            o_fb_we,
    output logic [ADDR_BITS:0]              o_fb_addr,
    output logic [DATA_BITS-1:0]            o_fb_wdata,
    input  logic [DATA_BITS-1:0]            i_fb_rdata
);

    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int LVL_BITS = PTR_BITS + 1;
    localparam logic [LVL_BITS-1:0] FULL_LVL = LVL_BITS'(FIFO_DEPTH);

    // CPU write FIFO
    logic [ADDR_BITS-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_BITS-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_BITS-1:0]  r_wr_ptr;
    logic [PTR_BITS-1:0]  r_rd_ptr;
    logic [LVL_BITS-1:0]  r_level;
    // Holds cpu_wr_ready low through reset and for the first cycle after it
    logic                 r_ready_en;

    // RAM command and readout pipeline
    logic                 r_fb_en;
    logic                 r_fb_we;
    logic [ADDR_BITS:0]   r_fb_addr;
    logic [DATA_BITS-1:0] r_fb_wdata;
    logic                 r_rd_p2;
    logic                 r_rd_valid;
    logic [DATA_BITS-1:0] r_rd_data;

    logic w_front;
    logic w_back;
    logic w_wr_ready;
    logic w_push;
    logic w_pop;

    // Readout owns the RAM whenever it asks; the FIFO only gets the leftover cycles
    assign w_push = i_cpu_wr_valid && w_wr_ready;
    assign w_pop  = !i_rd_req && (r_level != '0);

`ifdef POV_FB_DOUBLE_BUFFER_EN
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_WAIT_WRAP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_front;
    logic [THETA_BITS-1:0] r_theta_q;
    logic                  w_theta_wrap;
    logic                  w_swap_done;

    // A revolution boundary shows up as theta stepping backwards
    assign w_theta_wrap = (i_theta < r_theta_q);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_front   <= 1'b0;
            r_theta_q <= '0;
        end else begin
            r_state   <= w_state_next;
            r_theta_q <= i_theta;
            if (w_swap_done) begin
                r_front <= ~r_front;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_swap_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_swap_req) begin
                    w_state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // The last drained write may still be on the RAM port this cycle;
                // wait for it so every pre-swap write lands in the old back bank.
                if ((r_level == '0) && !(r_fb_en && r_fb_we)) begin
                    w_state_next = ST_WAIT_WRAP;
                end
            end
            ST_WAIT_WRAP: begin
                if (w_theta_wrap) begin
                    w_swap_done  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_front        = r_front;
    assign w_back         = ~r_front;
    assign w_wr_ready     = r_ready_en && (r_level < FULL_LVL) && (r_state != ST_ARMED);
    assign o_swap_pending = (r_state != ST_IDLE);
    assign o_swap_done    = w_swap_done;
`else
    logic r_swap_done;
    logic w_unused_theta;

    assign w_unused_theta = ^i_theta;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_swap_done <= 1'b0;
        end else begin
            r_swap_done <= i_swap_req;
        end
    end

    assign w_front        = 1'b0;
    assign w_back         = 1'b0;
    assign w_wr_ready     = r_ready_en && (r_level < FULL_LVL);
    assign o_swap_pending = 1'b0;
    assign o_swap_done    = r_swap_done;
`endif

    // FIFO storage needs no reset; the pointers define which entries are live
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= i_cpu_wr_addr;
            r_fifo_data[r_wr_ptr] <= i_cpu_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_ready_en <= 1'b0;
            r_fb_en    <= 1'b0;
            r_fb_we    <= 1'b0;
            r_fb_addr  <= '0;
            r_fb_wdata <= '0;
            r_rd_p2    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_ready_en <= 1'b1;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_BITS'(1);
                2'b01:   r_level <= r_level - LVL_BITS'(1);
                default: r_level <= r_level;
            endcase

            // Bank is captured here, so a later swap cannot redirect this access
            if (i_rd_req) begin
                r_fb_en   <= 1'b1;
                r_fb_we   <= 1'b0;
                r_fb_addr <= {w_front, i_rd_addr};
            end else if (w_pop) begin
                r_fb_en    <= 1'b1;
                r_fb_we    <= 1'b1;
                r_fb_addr  <= {w_back, r_fifo_addr[r_rd_ptr]};
                r_fb_wdata <= r_fifo_data[r_rd_ptr];
            end else begin
                r_fb_en <= 1'b0;
                r_fb_we <= 1'b0;
            end

            // RAM returns data the cycle after a read command; register it once more
            r_rd_p2    <= r_fb_en && !r_fb_we;
            r_rd_valid <= r_rd_p2;
            if (r_rd_p2) begin
                r_rd_data <= i_fb_rdata;
            end
        end
    end

    assign o_cpu_wr_ready = w_wr_ready;
    assign o_fifo_level   = r_level;
    assign o_fb_en        = r_fb_en;
    assign o_fb_we        = r_fb_we;
    assign o_fb_addr      = r_fb_addr;
    assign o_fb_wdata     = r_fb_wdata;
    assign o_rd_data      = r_rd_data;
    assign o_rd_valid     = r_rd_valid;

endmodule

// File: tb/tb_pov_fb_arbiter.sv
// tb/tb_pov_fb_arbiter.sv - directed scoreboard bench for pov_fb_arbiter
module tb_pov_fb_arbiter;

    logic        clk;
    logic        i_reset;
    logic        i_rd_req;
    logic [13:0] i_rd_addr;
    logic [23:0] o_rd_data;
    logic        o_rd_valid;
    logic        i_cpu_wr_valid;
    logic        o_cpu_wr_ready;
    logic [13:0] i_cpu_wr_addr;
    logic [23:0] i_cpu_wr_data;
    logic        i_swap_req;
    logic [5:0]  i_theta;
    logic        o_swap_pending;
    logic        o_swap_done;
    logic [3:0]  o_fifo_level;
    logic        o_fb_en;
    logic        o_fb_we;
    logic [14:0] o_fb_addr;
    logic [23:0] o_fb_wdata;
    logic [23:0] i_fb_rdata;

    pov_fb_arbiter dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_rd_req       (i_rd_req),
        .i_rd_addr      (i_rd_addr),
        .o_rd_data      (o_rd_data),
        .o_rd_valid     (o_rd_valid),
        .i_cpu_wr_valid (i_cpu_wr_valid),
        .o_cpu_wr_ready (o_cpu_wr_ready),
        .i_cpu_wr_addr  (i_cpu_wr_addr),
        .i_cpu_wr_data  (i_cpu_wr_data),
        .i_swap_req     (i_swap_req),
        .i_theta        (i_theta),
        .o_swap_pending (o_swap_pending),
        .o_swap_done    (o_swap_done),
        .o_fifo_level   (o_fifo_level),
        .o_fb_en        (o_fb_en),
        .o_fb_we        (o_fb_we),
        .o_fb_addr      (o_fb_addr),
        .o_fb_wdata     (o_fb_wdata),
        .i_fb_rdata     (i_fb_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] pat(input logic [14:0] a);
        if (a == 15'h0123) return 24'hFF0000;
        return {a[7:0], ~a[7:0], 1'b0, a[14:8]};
    endfunction

    // Framebuffer RAM: cells never written read back as pat(addr)
    bit [23:0] ram     [0:32767];
    bit        written [0:32767];
    initial i_fb_rdata = '0;
    always @(posedge clk) begin
        if (o_fb_en === 1'b1) begin
            if (o_fb_we) begin
                ram[o_fb_addr]     <= o_fb_wdata;
                written[o_fb_addr] <= 1'b1;
            end else begin
                i_fb_rdata <= written[o_fb_addr] ? ram[o_fb_addr] : pat(o_fb_addr);
            end
        end
    end

    typedef struct { int due; logic [23:0] data; } rd_t;
    typedef struct { logic [13:0] a; logic [23:0] d; } wr_t;
    rd_t rdq[$];
    wr_t mf[$];

    logic [23:0] shadow [0:32767];
    int          n_vec  = 0;
    int          n_fail = 0;
    int          cyc    = 0;

    // Stimulus for the coming cycle
    logic        s_rst, s_rd, s_wv, s_swap;
    logic [13:0] s_raddr, s_waddr;
    logic [23:0] s_wdata;
    logic [5:0]  s_theta;

    // Reference model state
    logic        e_fb_en, e_fb_we;
    logic [14:0] e_fb_addr;
    logic [23:0] e_fb_wdata;
    logic        m_en, m_front, m_sdone;
    logic [5:0]  m_theta_q;
    int          m_state;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic  exp_v, m_ready, wrap, pre_bus_wr, push, pop, m_back;
        int    pre_level;
        wr_t   w;
        @(posedge clk);
        cyc++;
        #1;
        chk("fb_en", 32'(o_fb_en), 32'(e_fb_en));
        if (e_fb_en) begin
            chk("fb_we", 32'(o_fb_we), 32'(e_fb_we));
            chk("fb_addr", 32'(o_fb_addr), 32'(e_fb_addr));
            if (e_fb_we) chk("fb_wdata", 32'(o_fb_wdata), 32'(e_fb_wdata));
        end
        exp_v = (rdq.size() > 0) && (rdq[0].due == cyc);
        chk("rd_valid", 32'(o_rd_valid), 32'(exp_v));
        if (exp_v) begin
            chk("rd_data", 32'(o_rd_data), 32'(rdq[0].data));
            void'(rdq.pop_front());
        end

        i_reset        = s_rst;
        i_rd_req       = s_rd;
        i_rd_addr      = s_raddr;
        i_cpu_wr_valid = s_wv;
        i_cpu_wr_addr  = s_waddr;
        i_cpu_wr_data  = s_wdata;
        i_swap_req     = s_swap;
        i_theta        = s_theta;
        #1;

        pre_level = mf.size();
        wrap      = (s_theta < m_theta_q);
`ifdef POV_FB_DOUBLE_BUFFER_EN
        m_ready = m_en && (pre_level < 8) && (m_state != 1);
        m_back  = ~m_front;
        chk("swap_pending", 32'(o_swap_pending), 32'(m_state != 0));
        chk("swap_done", 32'(o_swap_done), 32'((m_state == 2) && wrap));
`else
        m_ready = m_en && (pre_level < 8);
        m_back  = 1'b0;
        chk("swap_pending", 32'(o_swap_pending), 32'(0));
        chk("swap_done", 32'(o_swap_done), 32'(m_sdone));
`endif
        chk("wr_ready", 32'(o_cpu_wr_ready), 32'(m_ready));
        chk("fifo_level", 32'(o_fifo_level), 32'(pre_level));

        if (s_rst) begin
            mf.delete();
            rdq.delete();
            e_fb_en   = 1'b0;
            e_fb_we   = 1'b0;
            m_en      = 1'b0;
            m_front   = 1'b0;
            m_sdone   = 1'b0;
            m_theta_q = '0;
            m_state   = 0;
        end else begin
            pre_bus_wr = e_fb_en && e_fb_we;
            push = s_wv && m_ready;
            pop  = !s_rd && (pre_level > 0);
            if (s_rd) begin
                e_fb_en   = 1'b1;
                e_fb_we   = 1'b0;
                e_fb_addr = {m_front, s_raddr};
                rdq.push_back('{cyc + 3, shadow[e_fb_addr]});
            end else if (pop) begin
                w          = mf.pop_front();
                e_fb_en    = 1'b1;
                e_fb_we    = 1'b1;
                e_fb_addr  = {m_back, w.a};
                e_fb_wdata = w.d;
                shadow[e_fb_addr] = w.d;
            end else begin
                e_fb_en = 1'b0;
                e_fb_we = 1'b0;
            end
            if (push) mf.push_back('{s_waddr, s_wdata});
`ifdef POV_FB_DOUBLE_BUFFER_EN
            case (m_state)
                0: if (s_swap) m_state = 1;
                1: if ((pre_level == 0) && !pre_bus_wr) m_state = 2;
                default: if (wrap) begin m_front = ~m_front; m_state = 0; end
            endcase
`else
            m_sdone = s_swap;
`endif
            m_theta_q = s_theta;
            m_en      = 1'b1;
        end
    endtask

    task automatic drive(input logic rd, input logic [13:0] ra, input logic wv,
                         input logic [13:0] wa, input logic [23:0] wd,
                         input logic sw, input logic [5:0] th);
        s_rst = 1'b0; s_rd = rd; s_raddr = ra; s_wv = wv;
        s_waddr = wa; s_wdata = wd; s_swap = sw; s_theta = th;
        tick();
    endtask

    task automatic rst_tick();
        s_rst = 1'b1; s_rd = 1'b0; s_wv = 1'b0; s_swap = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) shadow[i] = pat(15'(i));
        i_reset = 1'b1; i_rd_req = 1'b0; i_rd_addr = '0; i_cpu_wr_valid = 1'b0;
        i_cpu_wr_addr = '0; i_cpu_wr_data = '0; i_swap_req = 1'b0; i_theta = '0;
        s_raddr = '0; s_waddr = '0; s_wdata = '0; s_theta = '0;
        e_fb_en = 1'b0; e_fb_we = 1'b0; e_fb_addr = '0; e_fb_wdata = '0;
        m_en = 1'b0; m_front = 1'b0; m_sdone = 1'b0; m_theta_q = '0; m_state = 0;

        // Reset, then release
        repeat (3) rst_tick();
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0);

        // T1: single read of the known pixel
        drive(1, 14'h0123, 0, 0, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0);

        // T2: fill FIFO behind continuous reads, overflow offers, full+pop, drain
        for (int i = 0; i < 10; i++)
            drive(1, 14'h0200 + 14'(i), 1, 14'h0100 + 14'(i), 24'hA00000 + 24'(i), 0, 0);
        for (int i = 0; i < 3; i++)
            drive(0, 0, 1, 14'h0110 + 14'(i), 24'hA10000 + 24'(i), 0, 0);
        repeat (12) drive(0, 0, 0, 0, 0, 0, 0);

        // T3: reads every other cycle with CPU writes interleaved
        for (int i = 0; i < 12; i++)
            drive((i % 2) == 0, 14'h0300 + 14'(i), i < 4, 14'h0010 + 14'(i), 24'h0000C0 + 24'(i), 0, 0);
        repeat (5) drive(0, 0, 0, 0, 0, 0, 0);

        // T4: 3 queued writes, swap request, commit on theta 63 -> 0
        for (int i = 0; i < 3; i++)
            drive(1, 14'h0400 + 14'(i), 1, 14'h0020 + 14'(i), 24'hD00000 + 24'(i), 0, 58);
        drive(0, 0, 0, 0, 0, 1, 59);
        drive(0, 0, 1, 14'h0030, 24'hD10000, 0, 60);
        drive(0, 0, 1, 14'h0031, 24'hD10001, 0, 61);
        drive(0, 0, 1, 14'h0032, 24'hD10002, 0, 62);
        drive(0, 0, 0, 0, 0, 0, 63);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 14'h0020, 0, 0, 0, 0, 1);
        drive(1, 14'h0021, 1, 14'h0040, 24'hD20000, 0, 2);
        repeat (5) drive(0, 0, 0, 0, 0, 0, 2);

        // T5: repeated swap_req ignored, wrap during ARMED not latched, 10->10 no commit
        for (int i = 0; i < 2; i++)
            drive(1, 14'h0500 + 14'(i), 1, 14'h0050 + 14'(i), 24'hB00000 + 24'(i), 0, 5);
        drive(1, 14'h0502, 0, 0, 0, 1, 6);
        drive(1, 14'h0503, 0, 0, 0, 1, 63);
        drive(1, 14'h0504, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 2);
        drive(0, 0, 0, 0, 0, 0, 3);
        drive(0, 0, 0, 0, 0, 1, 10);
        drive(0, 0, 0, 0, 0, 0, 10);
        drive(0, 0, 0, 0, 0, 0, 20);
        drive(0, 0, 0, 0, 0, 0, 63);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 14'h0050, 0, 0, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0);

        // T6: leave bank 1 in front, then reset over 5 queued writes and reads in flight
        drive(0, 0, 0, 0, 0, 1, 5);
        drive(0, 0, 0, 0, 0, 0, 6);
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            drive(1, 14'h0600 + 14'(i), 1, 14'h0700 + 14'(i), 24'hE00000 + 24'(i), 0, 0);
        repeat (2) rst_tick();
        repeat (6) drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 14'h0123, 0, 0, 0, 0, 0);
        repeat (5) drive(0, 0, 0, 0, 0, 0, 0);

        chk("reads_retired", 32'(rdq.size()), 32'(0));
        chk("writes_retired", 32'(mf.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
